// File: rtl/vx_perf_ctr_bank.sv
// vx_perf_ctr_bank
//   Parametrised bank of performance counters. Each cycle every source may
//   present one increment per counter; the per-counter sum over qualified
//   sources is registered, then added into the live counter. Live counters
//   can be copied into shadow registers (snapshot) and/or zeroed (clear) in
//   the same cycle. The shadows are read through an indexed request/response
//   port with a one-cycle response latency.
//
// Ports
//   clk, reset_n      clock, asynchronous active-low reset
//   enable            counting enable; increments presented while low are dropped
//   inc_valid         per-source qualifier
//   inc_data          increments, source-major, counter-minor, INC_BITS each
//   clear_req         zero live counters, overflow flags and stage-1 sums
//   snap_req          copy post-update live counters into the shadows
//   rd_req, rd_addr   shadow read request and counter index
//   rd_rsp_valid      response valid, exactly one cycle per request
//   rd_rsp_data       shadow value (0 for out-of-range index), held when idle
//   ctr_out           live counters, counter 0 at LSB
//   ovf_out           sticky per-counter overflow flags
module vx_perf_ctr_bank #(
    parameter int NUM_CTRS = 14,
    parameter int NUM_SRCS = 4,
    parameter int INC_BITS = 4,
    parameter int CTR_BITS = 44,
    parameter int SATURATE = 0
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic                                   enable,
    input  logic [NUM_SRCS-1:0]                    inc_valid,
    input  logic [NUM_SRCS*NUM_CTRS*INC_BITS-1:0]  inc_data,
    input  logic                                   clear_req,
    input  logic                                   snap_req,
    input  logic                                   rd_req,
    input  logic [$clog2(NUM_CTRS)-1:0]            rd_addr,
    output logic                                   rd_rsp_valid,
    output logic [CTR_BITS-1:0]                    rd_rsp_data,
    output logic [NUM_CTRS*CTR_BITS-1:0]           ctr_out,
    output logic [NUM_CTRS-1:0]                    ovf_out
);

    localparam int SRC_W = (NUM_SRCS > 1) ? $clog2(NUM_SRCS) : 1;
    localparam int SUM_W = INC_BITS + SRC_W;

    logic [SUM_W-1:0]    sum_p0  [NUM_CTRS];
    logic [SUM_W-1:0]    sum_p1  [NUM_CTRS];
    logic [CTR_BITS-1:0] ctr_p2  [NUM_CTRS];
    logic [CTR_BITS-1:0] ctr_upd [NUM_CTRS];
    logic [CTR_BITS-1:0] shadow  [NUM_CTRS];
    logic [NUM_CTRS-1:0] carry;

    // Returns {carry, new value}. In saturating mode a carry clamps the value
    // to all-ones; once there, every further non-zero add carries again, so
    // the counter stays pinned.
    function automatic logic [CTR_BITS:0] add_ctr(input logic [CTR_BITS-1:0] ctr,
                                                   input logic [SUM_W-1:0]    inc);
        logic [CTR_BITS:0] raw;
        raw = {1'b0, ctr} + {{(CTR_BITS + 1 - SUM_W){1'b0}}, inc};
        if (SATURATE != 0 && raw[CTR_BITS]) begin
            raw[CTR_BITS-1:0] = '1;
        end
        return raw;
    endfunction

    // ---- stage 0 -> 1: per-counter sum over qualified sources ----
    always_comb begin
        for (int c = 0; c < NUM_CTRS; c++) begin
            sum_p0[c] = '0;
            for (int s = 0; s < NUM_SRCS; s++) begin
                if (enable && inc_valid[s]) begin
                    sum_p0[c] = sum_p0[c]
                              + SUM_W'(inc_data[(s*NUM_CTRS + c)*INC_BITS +: INC_BITS]);
                end
            end
        end
    end

    // Clearing the stage-1 register as well drops the increments sampled on
    // the clear edge, so counting restarts cleanly on the following edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < NUM_CTRS; c++) sum_p1[c] <= '0;
        end else begin
            for (int c = 0; c < NUM_CTRS; c++) sum_p1[c] <= clear_req ? '0 : sum_p0[c];
        end
    end

    // ---- stage 1 -> 2: accumulate into live counters ----
    always_comb begin
        for (int c = 0; c < NUM_CTRS; c++) begin
            {carry[c], ctr_upd[c]} = add_ctr(ctr_p2[c], sum_p1[c]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < NUM_CTRS; c++) ctr_p2[c] <= '0;
            ovf_out <= '0;
        end else if (clear_req) begin
            for (int c = 0; c < NUM_CTRS; c++) ctr_p2[c] <= '0;
            ovf_out <= '0;
        end else begin
            for (int c = 0; c < NUM_CTRS; c++) ctr_p2[c] <= ctr_upd[c];
            ovf_out <= ovf_out | carry;
        end
    end

    // Shadows capture the post-update value, independent of clear_req, which
    // makes snap+clear in one cycle an atomic read-and-reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < NUM_CTRS; c++) shadow[c] <= '0;
        end else if (snap_req) begin
            for (int c = 0; c < NUM_CTRS; c++) shadow[c] <= ctr_upd[c];
        end
    end

    // ---- read port: response one cycle after request ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_rsp_valid <= 1'b0;
            rd_rsp_data  <= '0;
        end else begin
            rd_rsp_valid <= rd_req;
            if (rd_req) begin
                rd_rsp_data <= (int'(rd_addr) < NUM_CTRS) ? shadow[rd_addr] : '0;
            end
        end
    end

    for (genvar g = 0; g < NUM_CTRS; g++) begin : g_out
        assign ctr_out[g*CTR_BITS +: CTR_BITS] = ctr_p2[g];
    end

endmodule

// File: tb/tb_vx_perf_ctr_bank.sv
// Testbench for vx_perf_ctr_bank. Three instances share one stimulus:
//   a: 44-bit wrapping counters, w: 8-bit wrapping, s: 8-bit saturating.
// The reference model tracks, per counter, the total of accepted increments
// since the last clear/reset; each instance's counter and overflow flag are
// derived from that total by its width and overflow mode.
module tb_vx_perf_ctr_bank;

    localparam int NC = 14;
    localparam int NS = 4;
    localparam int IB = 4;

    logic                clk = 1'b0;
    logic                reset_n;
    logic                enable;
    logic [NS-1:0]       inc_valid;
    logic [NS*NC*IB-1:0] inc_data;
    logic                clear_req, snap_req, rd_req;
    logic [3:0]          rd_addr;

    logic                rv_a, rv_w, rv_s;
    logic [43:0]         rd_a;
    logic [7:0]          rd_w, rd_s;
    logic [NC*44-1:0]    ctr_a;
    logic [NC*8-1:0]     ctr_w, ctr_s;
    logic [NC-1:0]       ovf_a, ovf_w, ovf_s;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    vx_perf_ctr_bank #(.NUM_CTRS(NC), .NUM_SRCS(NS), .INC_BITS(IB), .CTR_BITS(44), .SATURATE(0)) u_a (
        .clk(clk), .reset_n(reset_n), .enable(enable), .inc_valid(inc_valid), .inc_data(inc_data),
        .clear_req(clear_req), .snap_req(snap_req), .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_rsp_valid(rv_a), .rd_rsp_data(rd_a), .ctr_out(ctr_a), .ovf_out(ovf_a));

    vx_perf_ctr_bank #(.NUM_CTRS(NC), .NUM_SRCS(NS), .INC_BITS(IB), .CTR_BITS(8), .SATURATE(0)) u_w (
        .clk(clk), .reset_n(reset_n), .enable(enable), .inc_valid(inc_valid), .inc_data(inc_data),
        .clear_req(clear_req), .snap_req(snap_req), .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_rsp_valid(rv_w), .rd_rsp_data(rd_w), .ctr_out(ctr_w), .ovf_out(ovf_w));

    vx_perf_ctr_bank #(.NUM_CTRS(NC), .NUM_SRCS(NS), .INC_BITS(IB), .CTR_BITS(8), .SATURATE(1)) u_s (
        .clk(clk), .reset_n(reset_n), .enable(enable), .inc_valid(inc_valid), .inc_data(inc_data),
        .clear_req(clear_req), .snap_req(snap_req), .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_rsp_valid(rv_s), .rd_rsp_data(rd_s), .ctr_out(ctr_s), .ovf_out(ovf_s));

    // ---------------- reference model ----------------
    longint tot  [NC];      // accepted increments since last clear, already applied
    longint infl [NC];      // accepted increments one edge away from being applied
    longint shd  [3][NC];   // shadow value as seen by each instance
    bit     exp_rv;
    longint exp_rd [3];

    function automatic longint lim_of(int i);
        return (i == 0) ? (longint'(1) << 44) : longint'(256);
    endfunction

    function automatic longint view(int i, longint t);
        if (i == 2) return (t >= lim_of(i)) ? lim_of(i) - 1 : t;
        return t % lim_of(i);
    endfunction

    function automatic longint presented_sum(int c);
        longint acc = 0;
        if (!enable) return 0;
        for (int s = 0; s < NS; s++)
            if (inc_valid[s]) acc += longint'(inc_data[(s*NC + c)*IB +: IB]);
        return acc;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < NC; c++) begin
                tot[c]  <= 0;
                infl[c] <= 0;
                for (int i = 0; i < 3; i++) shd[i][c] <= 0;
            end
            exp_rv <= 1'b0;
            for (int i = 0; i < 3; i++) exp_rd[i] <= 0;
        end else begin
            for (int c = 0; c < NC; c++) begin
                infl[c] <= clear_req ? 0 : presented_sum(c);
                tot[c]  <= clear_req ? 0 : tot[c] + infl[c];
                if (snap_req)
                    for (int i = 0; i < 3; i++) shd[i][c] <= view(i, tot[c] + infl[c]);
            end
            exp_rv <= rd_req;
            if (rd_req)
                for (int i = 0; i < 3; i++) exp_rd[i] <= (rd_addr < NC) ? shd[i][rd_addr] : 0;
        end
    end

    // ---------------- DUT accessors ----------------
    function automatic longint get_ctr(int i, int c);
        case (i)
            0:       return longint'(ctr_a[c*44 +: 44]);
            1:       return longint'(ctr_w[c*8 +: 8]);
            default: return longint'(ctr_s[c*8 +: 8]);
        endcase
    endfunction

    function automatic longint get_ovf(int i);
        case (i)
            0:       return longint'(ovf_a);
            1:       return longint'(ovf_w);
            default: return longint'(ovf_s);
        endcase
    endfunction

    function automatic longint get_rv(int i);
        case (i)
            0:       return longint'(rv_a);
            1:       return longint'(rv_w);
            default: return longint'(rv_s);
        endcase
    endfunction

    function automatic longint get_rd(int i);
        case (i)
            0:       return longint'(rd_a);
            1:       return longint'(rd_w);
            default: return longint'(rd_s);
        endcase
    endfunction

    function automatic longint exp_ovf(int i);
        longint r = 0;
        for (int c = 0; c < NC; c++)
            if (tot[c] >= lim_of(i)) r |= (longint'(1) << c);
        return r;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // ---------------- per-cycle compare against the model ----------------
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            for (int c = 0; c < NC; c++)
                chk($sformatf("model ctr inst%0d[%0d]", i, c), get_ctr(i, c), view(i, tot[c]));
            chk($sformatf("model ovf inst%0d", i), get_ovf(i), exp_ovf(i));
            chk($sformatf("model rd_valid inst%0d", i), get_rv(i), longint'(exp_rv));
            chk($sformatf("model rd_data inst%0d", i), get_rd(i), exp_rd[i]);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        inc_valid = '0;
        inc_data  = '0;
        clear_req = 1'b0;
        snap_req  = 1'b0;
        rd_req    = 1'b0;
        rd_addr   = '0;
    endtask

    task automatic put(input int s, input int c, input int v);
        inc_valid[s] = 1'b1;
        inc_data[(s*NC + c)*IB +: IB] = IB'(v);
    endtask

    task automatic fill(input int c, input int v);
        for (int s = 0; s < NS; s++) put(s, c, v);
    endtask

    task automatic do_clear();
        idle();
        clear_req = 1'b1;
        @(negedge clk);
        idle();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        enable  = 1'b1;
        idle();
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset ctr_a[3]", get_ctr(0, 3), 0);
        chk("reset ovf_a", get_ovf(0), 0);
        chk("reset rd_valid", get_rv(0), 0);
        reset_n = 1'b1;
        @(negedge clk);

        // two-edge latency
        put(0, 3, 5);
        @(negedge clk);
        idle();
        chk("latency ctr3 after one edge", get_ctr(0, 3), 0);
        @(negedge clk);
        chk("latency ctr3 after two edges", get_ctr(0, 3), 5);

        // 4 sources x 15 x 10 cycles
        do_clear();
        repeat (10) begin fill(0, 15); @(negedge clk); end
        idle();
        repeat (2) @(negedge clk);
        chk("sum600 ctr0", get_ctr(0, 0), 600);
        chk("sum600 ovf_a", get_ovf(0), 0);

        // saturation vs wrap on 8-bit counters
        do_clear();
        repeat (4) begin fill(5, 15); @(negedge clk); end
        idle(); put(0, 5, 10); @(negedge clk);
        idle(); repeat (2) @(negedge clk);
        chk("preset sat 250", get_ctr(2, 5), 250);
        chk("preset wrap 250", get_ctr(1, 5), 250);
        put(0, 5, 15); @(negedge clk);
        idle(); repeat (2) @(negedge clk);
        chk("sat clamp 255", get_ctr(2, 5), 255);
        chk("wrap 9", get_ctr(1, 5), 9);
        chk("sat ovf bit5", (get_ovf(2) >> 5) & 1, 1);
        chk("wrap ovf bit5", (get_ovf(1) >> 5) & 1, 1);
        chk("wide ctr5 265", get_ctr(0, 5), 265);
        put(0, 5, 15); @(negedge clk);
        idle(); repeat (2) @(negedge clk);
        chk("sat hold 255", get_ctr(2, 5), 255);
        chk("wrap 24", get_ctr(1, 5), 24);

        // atomic snapshot + clear
        do_clear();
        fill(7, 15); put(1, 1, 3); put(2, 2, 6); @(negedge clk);
        idle(); fill(7, 10); @(negedge clk);
        idle(); put(0, 7, 7); @(negedge clk);
        idle();
        chk("ctr7 at 100", get_ctr(0, 7), 100);
        clear_req = 1'b1; snap_req = 1'b1; put(0, 7, 9);
        @(negedge clk);
        idle();
        chk("ctr7 cleared", get_ctr(0, 7), 0);
        rd_req = 1'b1; rd_addr = 4'd7;
        @(negedge clk);
        chk("snap read valid", get_rv(0), 1);
        chk("snap read 107", get_rd(0), 107);
        chk("clear-cycle inc dropped", get_ctr(0, 7), 0);

        // back-to-back reads, last one out of range
        rd_addr = 4'd1;
        @(negedge clk);
        chk("read shadow1", get_rd(0), 3);
        rd_addr = 4'd2;
        @(negedge clk);
        chk("read shadow2", get_rd(0), 6);
        rd_addr = 4'd15;
        @(negedge clk);
        chk("read out of range", get_rd(0), 0);
        chk("read out of range valid", get_rv(0), 1);
        idle();
        @(negedge clk);
        chk("read idle valid", get_rv(0), 0);

        // enable low discards, in-flight sum still retires
        do_clear();
        put(0, 4, 2); @(negedge clk);
        enable = 1'b0; inc_valid = '1; inc_data = '1;
        repeat (5) @(negedge clk);
        enable = 1'b1; idle();
        repeat (2) @(negedge clk);
        chk("enable-low ctr4", get_ctr(0, 4), 2);
        chk("enable-low ctr0", get_ctr(0, 0), 0);

        // asynchronous reset mid-count
        repeat (6) begin fill(0, 15); rd_req = 1'b1; rd_addr = 4'd1; @(negedge clk); end
        chk("pre-reset wrap ovf0", get_ovf(1) & 1, 1);
        chk("pre-reset rd_valid", get_rv(0), 1);
        #2 reset_n = 1'b0;
        idle();
        #1;
        chk("async reset ctr0", get_ctr(0, 0), 0);
        chk("async reset ovf_w", get_ovf(1), 0);
        chk("async reset rd_valid", get_rv(0), 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        put(3, 13, 9); @(negedge clk);
        idle(); @(negedge clk);
        chk("post-reset ctr13", get_ctr(0, 13), 9);
        chk("post-reset sat ctr13", get_ctr(2, 13), 9);

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
